// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: direction input conditioner for the snake game engine.
// Each of the four raw buttons is synchronized through two flops and then
// debounced. A debounced press becomes a turn request. The request is
// accepted only if it is not a repeat and not a 180-degree reversal of the
// heading it would follow. Accepted turns are buffered, and one buffered
// turn is committed to dir_out on each game step strobe.
//
// Optional feature: SNAKE_TURN_QUEUE_EN
//   defined   : 2-entry turn FIFO. A request is checked against the newest
//               queued turn. A request that arrives while the FIFO is full
//               is dropped.
//   undefined : single pending slot. A request is checked against dir_out.
//               A newly accepted request overwrites the slot.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   up/right/
//   down/left   in   raw push-buttons, asynchronous, active high
//   step        in   one-cycle game tick strobe
//   dir_out     out  committed heading (0=up 1=right 2=down 3=left)
//   dir_changed out  one-cycle pulse in the cycle after dir_out was updated
//   pending     out  number of buffered turns

// Per-button synchronizer, debouncer and press-edge detector.
module snake_btn_deb #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2, lvl, lvl_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_d <= lvl;
            // The counter only runs while the synced input disagrees with
            // the debounced level. Any agreement restarts the count.
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                lvl <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Rising edge only. Releases do not produce an event.
    assign press = lvl & ~lvl_d;
endmodule

module snake_dir_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         CNT_W           = 19,
    parameter logic [1:0] INIT_DIR        = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       right,
    input  logic       down,
    input  logic       left,
    input  logic       step,
    output logic [1:0] dir_out,
    output logic       dir_changed,
    output logic [1:0] pending
);
    // Bit index equals the direction code, so the lowest set bit is the
    // highest-priority request (up > right > down > left).
    logic [3:0] raw, press;
    assign raw = {left, down, right, up};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_btn
            snake_btn_deb #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_deb (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw[g]),
                .press(press[g])
            );
        end
    endgenerate

    logic       req_vld;
    logic [1:0] req;

    always_comb begin
        req_vld = |press;
        req     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) req = 2'(i);
        end
    end

    logic [1:0] ref_dir;
    logic       accept;
    logic       pop;
    logic [1:0] nxt_dir;

`ifdef SNAKE_TURN_QUEUE_EN
    logic [1:0][1:0] q;
    logic            hd, tl;
    logic [1:0]      cnt;

    always_comb begin
        // With one pointer bit, the newest entry sits at tl-1, which is ~tl.
        ref_dir = (cnt != 2'd0) ? q[~tl] : dir_out;
        accept  = req_vld && (req != ref_dir) && (req != (ref_dir ^ 2'b10))
                  && (cnt != 2'd2);
        pop     = step && (cnt != 2'd0);
        nxt_dir = q[hd];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= '0;
            hd  <= 1'b0;
            tl  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (accept) begin
                q[tl] <= req;
                tl    <= ~tl;
            end
            if (pop) hd <= ~hd;
            case ({accept, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign pending = cnt;
`else
    logic [1:0] slot;
    logic       slot_vld;

    always_comb begin
        ref_dir = dir_out;
        accept  = req_vld && (req != ref_dir) && (req != (ref_dir ^ 2'b10));
        pop     = step && slot_vld;
        nxt_dir = slot;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot     <= 2'd0;
            slot_vld <= 1'b0;
        end else begin
            // A fresh request replaces whatever is waiting. If the slot is
            // committed in the same cycle, the new request stays behind
            // for the next step.
            if (accept) slot <= req;
            slot_vld <= accept | (slot_vld & ~pop);
        end
    end

    assign pending = {1'b0, slot_vld};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_out     <= INIT_DIR;
            dir_changed <= 1'b0;
        end else begin
            dir_changed <= pop && (nxt_dir != dir_out);
            if (pop) dir_out <= nxt_dir;
        end
    end
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4.
// The reference model keeps a per-button history of raw samples. A
// debounced level flips once the last DEBOUNCE_CYCLES synchronized samples
// all disagree with it. Buffered turns are held in a queue.
module tb_snake_dir_ctrl;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, up, right, down, left, step;
    logic [1:0] dir_out, pending;
    logic       dir_changed;

    int n_chk = 0;
    int n_err = 0;

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .INIT_DIR(2'd1)) dut (
        .clk(clk), .rst(rst), .up(up), .right(right), .down(down),
        .left(left), .step(step), .dir_out(dir_out),
        .dir_changed(dir_changed), .pending(pending)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_dir;
    int m_q[$];
    int m_chg;
    int m_hist[4][$];
    int m_deb[4];
    int m_rose[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dir = 1;
        m_q.delete();
        m_chg = 0;
        for (int b = 0; b < 4; b++) begin
            m_hist[b].delete();
            for (int k = 0; k < D + 2; k++) m_hist[b].push_back(0);
            m_deb[b]  = 0;
            m_rose[b] = 0;
        end
    endtask

    // State after one rising clock edge with the given inputs applied.
    task automatic model_edge(input bit [3:0] btn, input bit stp);
        int req, refd, acc, nd, n, all;
        req = -1;
        for (int b = 0; b < 4; b++) if (m_rose[b] != 0 && req < 0) req = b;
`ifdef SNAKE_TURN_QUEUE_EN
        refd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
        acc  = (req >= 0 && m_q.size() < 2 && req != refd && req != (refd ^ 2)) ? 1 : 0;
`else
        refd = m_dir;
        acc  = (req >= 0 && req != refd && req != (refd ^ 2)) ? 1 : 0;
`endif
        m_chg = 0;
        if (stp && m_q.size() > 0) begin
            nd    = m_q.pop_front();
            m_chg = (nd != m_dir) ? 1 : 0;
            m_dir = nd;
        end
        if (acc != 0) begin
`ifndef SNAKE_TURN_QUEUE_EN
            m_q.delete();
`endif
            m_q.push_back(req);
        end
        for (int b = 0; b < 4; b++) begin
            m_hist[b].push_back(btn[b] ? 1 : 0);
            n = m_hist[b].size();
            // Synchronized sample seen at this edge = raw from two edges ago.
            all = 1;
            for (int k = 0; k < D; k++) if (m_hist[b][n-3-k] == m_deb[b]) all = 0;
            m_rose[b] = 0;
            if (all != 0) begin
                m_deb[b]  = 1 - m_deb[b];
                m_rose[b] = m_deb[b];
            end
            while (m_hist[b].size() > D + 3) void'(m_hist[b].pop_front());
        end
    endtask

    // Drive inputs just after a falling edge, advance the model across the
    // next rising edge, then compare at the following falling edge.
    task automatic tick(input bit [3:0] btn, input bit stp);
        {left, down, right, up} = btn;
        step = stp;
        if (!rst) model_reset();
        else      model_edge(btn, stp);
        @(negedge clk);
        chk("dir_out", dir_out, m_dir);
        chk("pending", pending, m_q.size());
        chk("dir_changed", dir_changed, m_chg);
    endtask

    task automatic press(input int b);
        bit [3:0] m;
        m = '0;
        m[b] = 1'b1;
        repeat (8) tick(m, 1'b0);
        repeat (8) tick(4'b0, 1'b0);
    endtask

    initial begin
        int lat;
        bit [3:0] msk;
        int dur;
        rst = 1'b0; up = 1'b0; right = 1'b0; down = 1'b0; left = 1'b0; step = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_dir", dir_out, 1);
        chk("rst_pend", pending, 0);
        chk("rst_chg", dir_changed, 0);
        rst = 1'b1;

        // 1: idle steps
        repeat (5) begin tick(4'b0, 1'b1); tick(4'b0, 1'b0); end
        chk("t1_dir", dir_out, 1);

        // 2: hold up, measure press latency, then step
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(4'b0001, 1'b0);
            if (pending == 2'd1 && lat == 0) lat = i;
        end
        chk("t2_lat", lat, 2 + D + 1);
        repeat (8) tick(4'b0, 1'b0);
        tick(4'b0, 1'b1);
        chk("t2_dir", dir_out, 0);
        chk("t2_chg", dir_changed, 1);
        tick(4'b0, 1'b0);
        chk("t2_chg_off", dir_changed, 0);

        // 3: back to right, then a reversal and a repeat
        press(1); tick(4'b0, 1'b1);
        chk("t3_dir0", dir_out, 1);
        press(3); tick(4'b0, 1'b1);
        chk("t3_rev", dir_out, 1);
        press(1);
        chk("t3_rep", pending, 0);

        // 4: queue depth
        press(0); press(3); press(2);
`ifdef SNAKE_TURN_QUEUE_EN
        chk("t4_pend", pending, 2);
        tick(4'b0, 1'b1); chk("t4_s1", dir_out, 0);
        tick(4'b0, 1'b1); chk("t4_s2", dir_out, 3);
`else
        chk("t4_pend", pending, 1);
        tick(4'b0, 1'b1); chk("t4_s1", dir_out, 2);
`endif
        tick(4'b0, 1'b0);

        // 5: bounce on right starting from heading up
        press(1); tick(4'b0, 1'b1);
        press(0); tick(4'b0, 1'b1);
        chk("t5_start", dir_out, 0);
        for (int i = 0; i < 20; i++) tick((i % 4) < 2 ? 4'b0010 : 4'b0000, 1'b0);
        chk("t5_bounce", pending, 0);
        repeat (10) tick(4'b0010, 1'b0);
        chk("t5_hold", pending, 1);
        repeat (8) tick(4'b0, 1'b0);
        tick(4'b0, 1'b1);

        // 6: asynchronous reset with turns queued
        press(0); press(3);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_dir", dir_out, 1);
        chk("t6_pend", pending, 0);
        chk("t6_chg", dir_changed, 0);
        model_reset();
        @(negedge clk);
        tick(4'b0, 1'b1);
        rst = 1'b1;
        tick(4'b0, 1'b1);
        chk("t6_after", dir_out, 1);

        // Random phase: glitches, holds, multi-button presses, steps, resets
        for (int s = 0; s < 150; s++) begin
            case ($urandom_range(0, 5))
                0:       msk = 4'b0;
                1:       msk = 4'($urandom_range(0, 15));
                default: msk = 4'b0001 << $urandom_range(0, 3);
            endcase
            dur = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                              : int'($urandom_range(5, 12));
            if ($urandom_range(0, 39) == 0) rst = 1'b0;
            for (int c = 0; c < dur; c++) begin
                tick(msk, ($urandom_range(0, 5) == 0));
                if (!rst && c >= 1) rst = 1'b1;
            end
            rst = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
